// File: rtl/pattern_recognition_pkg.sv
// Shared types for the pattern_recognition block: readout FSM states,
// the per-pixel tag carried through the skid FIFO, and FIFO sizing.
package pattern_recognition_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } stream_state_t;

  // One captured edge bit plus its frame markers; widened to W bits at the FIFO output.
  typedef struct packed {
    logic bit_val;
    logic sof;
    logic eol;
  } pix_tag_t;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/stream_skid_fifo.sv
// 4-entry synchronous FIFO of pix_tag_t with occupancy count.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module stream_skid_fifo
  import pattern_recognition_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  pix_tag_t              push_data,
  input  logic                  pop,
  output pix_tag_t              head,
  output logic [FIFO_CNT_W-1:0] count
);

  pix_tag_t              mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Entry storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/edge_frame_streamer.sv
// Streams a captured binary edge frame out of the BRAM read port as a
// W-bit valid/ready pixel stream with start-of-frame and end-of-line tags.
// Optional feature macro: EDGE_STREAM_BORDER_MASK_EN zeroes the outer
// ring of pixels (first/last row, first/last column).
module edge_frame_streamer
  import pattern_recognition_pkg::*;
#(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  parameter  int W          = 8,
  localparam int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_to_read,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] read_addr,
  input  logic              read_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [W-1:0]      y_data,
  output logic              y_sof,
  output logic              y_eol
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);

  stream_state_t         state;
  logic [ADDR_W-1:0]     addr_cnt;
  logic [COL_W-1:0]      col_cnt;
  logic [ROW_W-1:0]      row_cnt;
  logic                  abort_q;

  // req_*: address on read_addr this cycle; land_*: its data on read_data this cycle.
  logic                  req_q;
  logic                  req_sof;
  logic                  req_eol;
  logic                  land_q;
  logic                  land_sof;
  logic                  land_eol;

  logic                  issue;
  logic                  credit_ok;
  logic [3:0]            occ_after;

  logic                  fifo_push;
  logic                  fifo_pop;
  pix_tag_t              fifo_in;
  pix_tag_t              fifo_head;
  logic [FIFO_CNT_W-1:0] fifo_count;

  // Occupancy is taken after this cycle's pop so a steady one-per-cycle
  // stream keeps issuing; worst case the FIFO holds 3 of its 4 entries.
  always_comb begin
    occ_after = 4'(fifo_count) - 4'(fifo_pop) + 4'(req_q) + 4'(land_q);
    credit_ok = (occ_after <= 4'd2);
    issue     = (state == STREAM) && valid_to_read && credit_ok;
  end

  // Readout FSM, address/row/column counters and the read pipeline tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      abort_q   <= 1'b0;
      read_addr <= '0;
      req_q     <= 1'b0;
      req_sof   <= 1'b0;
      req_eol   <= 1'b0;
      land_q    <= 1'b0;
      land_sof  <= 1'b0;
      land_eol  <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done     <= 1'b0;
      aborted  <= 1'b0;
      req_q    <= issue;
      land_q   <= req_q;
      land_sof <= req_sof;
      land_eol <= req_eol;
      case (state)
        IDLE: begin
          if (start && valid_to_read) begin
            state    <= STREAM;
            addr_cnt <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            abort_q  <= 1'b0;
          end
        end
        STREAM: begin
          if (!valid_to_read) begin
            abort_q <= 1'b1;
            state   <= DRAIN;
          end else if (issue) begin
            read_addr <= addr_cnt;
            req_sof   <= (addr_cnt == '0);
            req_eol   <= (col_cnt == LAST_COL);
            if (addr_cnt == LAST_ADDR) begin
              state <= DRAIN;
            end else begin
              addr_cnt <= addr_cnt + ADDR_W'(1);
              if (col_cnt == LAST_COL) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + ROW_W'(1);
              end else begin
                col_cnt <= col_cnt + COL_W'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (!req_q && !land_q &&
              ((fifo_count == '0) || ((fifo_count == FIFO_CNT_W'(1)) && fifo_pop))) begin
            state <= IDLE;
            if (abort_q) aborted <= 1'b1;
            else         done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EDGE_STREAM_BORDER_MASK_EN
  logic req_border;
  logic land_border;

  // Border flag travels alongside the read so the mask lines up with read_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_border  <= 1'b0;
      land_border <= 1'b0;
    end else begin
      if (issue) begin
        req_border <= (row_cnt == '0) || (row_cnt == ROW_W'(IMG_HEIGHT - 1)) ||
                      (col_cnt == '0) || (col_cnt == LAST_COL);
      end
      land_border <= req_border;
    end
  end

  // Landed bit with the outer ring forced to zero.
  always_comb begin
    fifo_in.bit_val = read_data && !land_border;
    fifo_in.sof     = land_sof;
    fifo_in.eol     = land_eol;
  end
`else
  // Landed bit passed through unmodified.
  always_comb begin
    fifo_in.bit_val = read_data;
    fifo_in.sof     = land_sof;
    fifo_in.eol     = land_eol;
  end
`endif

  assign fifo_push = land_q;
  assign fifo_pop  = y_valid && y_ready;

  stream_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign busy    = (state != IDLE);
  assign y_valid = (fifo_count != '0);
  assign y_data  = (y_valid && fifo_head.bit_val) ? '1 : '0;
  assign y_sof   = y_valid && fifo_head.sof;
  assign y_eol   = y_valid && fifo_head.eol;

endmodule

// File: tb/tb_edge_frame_streamer.sv
// Self-checking bench for edge_frame_streamer on a 4x3 frame with a
// 1-cycle-latency BRAM model. Honours EDGE_STREAM_BORDER_MASK_EN when defined.
module tb_edge_frame_streamer;

  localparam int IW = 4;
  localparam int IH = 3;
  localparam int PW = 8;
  localparam int N  = IW * IH;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_to_read;
  logic          start;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [AW-1:0] read_addr;
  logic          read_data = 1'b0;
  logic          y_valid;
  logic          y_ready;
  logic [PW-1:0] y_data;
  logic          y_sof;
  logic          y_eol;

  always #5 clk = ~clk;

  edge_frame_streamer #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_to_read (valid_to_read),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .read_addr     (read_addr),
    .read_data     (read_data),
    .y_valid       (y_valid),
    .y_ready       (y_ready),
    .y_data        (y_data),
    .y_sof         (y_sof),
    .y_eol         (y_eol)
  );

  // BRAM model: data for the address presented this cycle appears next cycle.
  logic mem [16];
  always @(posedge clk) read_data <= mem[read_addr];

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: pixel value and tags derived from the frame position.
  function automatic logic [PW-1:0] model_pix(input int a, input bit ones);
    int  row = a / IW;
    int  col = a % IW;
    bit  b   = ones ? 1'b1 : (((row + col) % 2) == 0);
`ifdef EDGE_STREAM_BORDER_MASK_EN
    if (row == 0 || row == IH - 1 || col == 0 || col == IW - 1) b = 1'b0;
`endif
    return b ? {PW{1'b1}} : {PW{1'b0}};
  endfunction

  task automatic load_mem(input bit ones);
    for (int a = 0; a < 16; a++) mem[a] = ones ? 1'b1 : ((((a / IW) + (a % IW)) % 2) == 0);
  endtask

  typedef struct {
    logic [PW-1:0] data;
    logic          sof;
    logic          eol;
    int            lat;
  } vec_t;
  vec_t tbl [N];

  task automatic build_table(input bit ones);
    for (int i = 0; i < N; i++) begin
      tbl[i].data = model_pix(i, ones);
      tbl[i].sof  = (i == 0);
      tbl[i].eol  = ((i % IW) == IW - 1);
      tbl[i].lat  = 3 + i;
    end
  endtask

  // Monitor: records transfers and completion pulses, checks stall stability.
  typedef struct {
    logic [PW-1:0] data;
    logic          sof;
    logic          eol;
    int            cyc;
  } pix_t;
  pix_t got[$];
  int   done_cnt  = 0;
  int   abort_cnt = 0;
  int   done_cyc  = 0;
  logic          hold_valid = 1'b0;
  logic [PW+1:0] hold_payload;

  always @(negedge clk) begin
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      if (y_valid && y_ready) got.push_back('{y_data, y_sof, y_eol, edge_n});
      if (done) begin done_cnt++; done_cyc = edge_n; end
      if (aborted) abort_cnt++;
      if (done || aborted) check("done_xor_aborted", {31'd0, done && aborted}, 32'd0);
      if (hold_valid) check("stall_payload_stable", {31'd0, y_valid && ({y_data, y_sof, y_eol} == hold_payload)}, 32'd1);
      check("fifo_no_overflow", {31'd0, dut.fifo_push && (dut.fifo_count == 3'd4) && !dut.fifo_pop}, 32'd0);
      hold_valid   = y_valid && !y_ready;
      hold_payload = {y_data, y_sof, y_eol};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    done_cnt  = 0;
    abort_cnt = 0;
    done_cyc  = 0;
  endtask

  // Pulse start, then run until busy drops (bounded); optional random y_ready.
  task automatic run_frame(input bit rand_ready, output int e0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e0 = edge_n;
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      if (rand_ready) y_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("frame_timeout", {31'd0, busy}, 32'd0);
    y_ready = 1'b1;
    tick(2);
  endtask

  task automatic compare_frame(input string tag, input int n, input int e0, input bit timed);
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), {24'd0, got[i].data}, {24'd0, tbl[i].data});
      check($sformatf("%s_sof%0d", tag, i), {31'd0, got[i].sof}, {31'd0, tbl[i].sof});
      check($sformatf("%s_eol%0d", tag, i), {31'd0, got[i].eol}, {31'd0, tbl[i].eol});
      if (timed) check($sformatf("%s_cyc%0d", tag, i), got[i].cyc - e0, tbl[i].lat);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_aborted"}, {31'd0, aborted}, 32'd0);
    check({tag, "_y_valid"}, {31'd0, y_valid}, 32'd0);
    check({tag, "_y_sof"}, {31'd0, y_sof}, 32'd0);
    check({tag, "_y_eol"}, {31'd0, y_eol}, 32'd0);
    check({tag, "_y_data"}, {24'd0, y_data}, 32'd0);
    check({tag, "_read_addr"}, {28'd0, read_addr}, 32'd0);
  endtask

  int e0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    valid_to_read = 1'b1;
    y_ready = 1'b1;
    load_mem(1'b0);
    tick(3);
    rst = 1'b0;
    tick(1);
    check_all_zero("reset");

    // Full checkerboard frame, y_ready held high.
    build_table(1'b0);
    clear_mon();
    run_frame(1'b0, e0);
    compare_frame("full", N, e0, 1'b1);
    check("full_done_cnt", done_cnt, 1);
    check("full_done_cyc", done_cyc - e0, N + 3);
    check("full_abort_cnt", abort_cnt, 0);

    // Random backpressure: same sequence, nothing lost or duplicated.
    for (int r = 0; r < 3; r++) begin
      clear_mon();
      run_frame(1'b1, e0);
      compare_frame($sformatf("rand%0d", r), N, e0, 1'b0);
      check("rand_done_cnt", done_cnt, 1);
      check("rand_abort_cnt", abort_cnt, 0);
    end

    // start without valid_to_read is ignored.
    clear_mon();
    valid_to_read = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    check("ignored_start_busy", {31'd0, busy}, 32'd0);
    check("ignored_start_pixels", got.size(), 0);
    valid_to_read = 1'b1;

    // start pulsed while busy is ignored: exactly one done.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    e0 = edge_n;
    tick(4);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    for (int k = 0; k < 200 && busy; k++) tick(1);
    tick(6);
    compare_frame("busy_start", N, e0, 1'b1);
    check("busy_start_done_cnt", done_cnt, 1);
    check("busy_start_idle", {31'd0, busy}, 32'd0);

    // valid_to_read drops after 5 addresses issued.
    clear_mon();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    check("abort_last_addr", {28'd0, read_addr}, 32'd4);
    valid_to_read = 1'b0;
    for (int k = 0; k < 100 && busy; k++) tick(1);
    tick(2);
    compare_frame("abort", 5, 0, 1'b0);
    check("abort_aborted_cnt", abort_cnt, 1);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    valid_to_read = 1'b1;
    tick(1);

    // Reset mid-frame with y_ready low, then a clean frame.
    clear_mon();
    y_ready = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick(2);
    rst = 1'b0;
    y_ready = 1'b1;
    tick(1);
    clear_mon();
    run_frame(1'b0, e0);
    compare_frame("post_rst", N, e0, 1'b1);
    check("post_rst_done_cnt", done_cnt, 1);

    // All-ones frame (border ring zero when masking is compiled in).
    load_mem(1'b1);
    build_table(1'b1);
    clear_mon();
    run_frame(1'b0, e0);
    compare_frame("ones", N, e0, 1'b1);
    check("ones_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
